ma_vrf_load_mover: RTL and testbench



---
 rtl/ma_vrf_load_mover.sv | 215 +++++++++++++++++++++
 tb/tb_ma_vrf_load_mover.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_vrf_load_mover.sv
// ma_vrf_load_mover
//   Moves one block of rows from DDR4 into the VRF BRAM. A command
//   (source byte address, first VRF row, byte count) is turned into a
//   sequence of AXI4 INCR read bursts. No burst crosses a 4 KB boundary,
//   and only one burst is outstanding at a time. Returned beats are packed
//   little-endian into VRF-wide rows. Each row is written to consecutive
//   BRAM rows. done_o pulses once after the last row write has been driven.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i               command strobe (sampled in IDLE only)
//   src_axi_addr_i        DDR4 source byte address (aligned down to a beat)
//   dst_bram_addr_i       first VRF row
//   byte_to_trans_i       byte count (partial trailing rows are dropped)
//   done_o                one-cycle completion pulse
//   err_o                 sticky non-OKAY rresp flag for the current command
//   m_axi_ar*/m_axi_r*    AXI4 read address / read data channels
//   vrf_en_o/we_o/addr_o/din_o  BRAM write port
module ma_vrf_load_mover #(
    parameter int unsigned DDR4_ADDRWIDTH  = 36,
    parameter int unsigned AXI_DATAWIDTH   = 512,
    parameter int unsigned VRF_ADDRWIDTH   = 10,
    parameter int unsigned VRF_DATAWIDTH   = 1024,
    parameter int unsigned MAX_BURST_BEATS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [DDR4_ADDRWIDTH-1:0] src_axi_addr_i,
    input  logic [VRF_ADDRWIDTH-1:0]  dst_bram_addr_i,
    input  logic [14:0]               byte_to_trans_i,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [DDR4_ADDRWIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [AXI_DATAWIDTH-1:0]  m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    output logic                      vrf_en_o,
    output logic                      vrf_we_o,
    output logic [VRF_ADDRWIDTH-1:0]  vrf_addr_o,
    output logic [VRF_DATAWIDTH-1:0]  vrf_din_o
);

    localparam int unsigned BPB           = AXI_DATAWIDTH / 8;
    localparam int unsigned LOG_BPB       = $clog2(BPB);
    localparam int unsigned BEATS_PER_ROW = VRF_DATAWIDTH / AXI_DATAWIDTH;
    localparam int unsigned ROW_SHIFT     = $clog2(VRF_DATAWIDTH / 8);
    localparam int unsigned BEAT_W        = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int unsigned REM_W         = 16 + $clog2(BEATS_PER_ROW);
    localparam int unsigned BOUND_BEATS   = 4096 / BPB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE_AR,
        S_RECV,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;

    logic [DDR4_ADDRWIDTH-1:0] r_addr;
    logic [REM_W-1:0]          r_remaining;
    logic [VRF_ADDRWIDTH-1:0]  r_row_ptr;
    logic [BEAT_W-1:0]         r_beat_idx;
    logic [VRF_DATAWIDTH-1:0]  r_row;
    logic                      r_err;
    logic                      r_done;
    logic                      r_vrf_en;
    logic [VRF_ADDRWIDTH-1:0]  r_vrf_addr;
    logic [VRF_DATAWIDTH-1:0]  r_vrf_din;

    logic [REM_W-1:0]          w_total_beats;
    logic [REM_W-1:0]          w_bound;
    logic [REM_W-1:0]          w_burst;
    logic                      w_accept;
    logic                      w_beat;
    logic                      w_row_last;
    logic [VRF_DATAWIDTH-1:0]  w_row_next;
    logic [DDR4_ADDRWIDTH-1:0] w_src_aligned;

    assign w_accept      = (r_state == S_IDLE) && start_i;
    assign w_beat        = (r_state == S_RECV) && m_axi_rvalid;
    assign w_row_last    = (r_beat_idx == BEAT_W'(BEATS_PER_ROW - 1));
    assign w_src_aligned = src_axi_addr_i & ~DDR4_ADDRWIDTH'(BPB - 1);
    assign w_total_beats = REM_W'(byte_to_trans_i >> ROW_SHIFT) * REM_W'(BEATS_PER_ROW);

    // Beats left before the next 4 KB page boundary from the current address.
    assign w_bound = REM_W'(BOUND_BEATS) - REM_W'(r_addr[11:LOG_BPB]);

    // The burst length depends only on r_addr / r_remaining. Both hold still
    // from ISSUE_AR until the rlast beat. So arlen stays stable, and the same
    // value can be reused to advance the pointers at rlast.
    always_comb begin
        w_burst = r_remaining;
        if (w_burst > REM_W'(MAX_BURST_BEATS)) begin
            w_burst = REM_W'(MAX_BURST_BEATS);
        end
        if (w_burst > w_bound) begin
            w_burst = w_bound;
        end
    end

    // Current beat is dropped into its slot; the first beat of a row lands lowest.
    always_comb begin
        w_row_next = r_row;
        w_row_next[int'(r_beat_idx) * AXI_DATAWIDTH +: AXI_DATAWIDTH] = m_axi_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        m_axi_arvalid = 1'b0;
        m_axi_arlen   = '0;
        m_axi_rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = (w_total_beats == '0) ? S_DONE : S_ISSUE_AR;
                end
            end
            S_ISSUE_AR: begin
                m_axi_arvalid = 1'b1;
                m_axi_arlen   = 8'(w_burst - 1'b1);
                if (m_axi_arready) begin
                    w_next = S_RECV;
                end
            end
            S_RECV: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && m_axi_rlast) begin
                    w_next = (r_remaining == w_burst) ? S_DONE : S_ISSUE_AR;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_row_ptr   <= '0;
            r_beat_idx  <= '0;
            r_row       <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_vrf_en    <= 1'b0;
            r_vrf_addr  <= '0;
            r_vrf_din   <= '0;
        end else begin
            r_vrf_en <= 1'b0;
            // Registered one cycle behind DONE so the pulse trails the final write.
            r_done   <= (r_state == S_DONE);

            if (w_accept) begin
                r_addr      <= w_src_aligned;
                r_remaining <= w_total_beats;
                r_row_ptr   <= dst_bram_addr_i;
                r_beat_idx  <= '0;
                r_err       <= 1'b0;
            end

            if (w_beat) begin
                r_row <= w_row_next;
                if (m_axi_rresp != 2'b00) begin
                    r_err <= 1'b1;
                end
                if (w_row_last) begin
                    r_vrf_en   <= 1'b1;
                    r_vrf_addr <= r_row_ptr;
                    r_vrf_din  <= w_row_next;
                    r_row_ptr  <= r_row_ptr + 1'b1;
                    r_beat_idx <= '0;
                end else begin
                    r_beat_idx <= r_beat_idx + 1'b1;
                end
                if (m_axi_rlast) begin
                    r_addr      <= r_addr + (DDR4_ADDRWIDTH'(w_burst) << LOG_BPB);
                    r_remaining <= r_remaining - w_burst;
                end
            end
        end
    end

    assign done_o        = r_done;
    assign err_o         = r_err;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arsize  = 3'(LOG_BPB);
    assign m_axi_arburst = 2'b01;
    assign vrf_en_o      = r_vrf_en;
    assign vrf_we_o      = r_vrf_en;
    assign vrf_addr_o    = r_vrf_addr;
    assign vrf_din_o     = r_vrf_din;

endmodule

// File: tb/tb_ma_vrf_load_mover.sv
// Directed testbench for ma_vrf_load_mover with a behavioural AXI read slave.
// The slave returns data that is a pure function of the beat address.
module tb_ma_vrf_load_mover;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [35:0]   src_axi_addr_i;
    logic [9:0]    dst_bram_addr_i;
    logic [14:0]   byte_to_trans_i;
    logic          done_o;
    logic          err_o;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [35:0]   m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [511:0]  m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          vrf_en_o;
    logic          vrf_we_o;
    logic [9:0]    vrf_addr_o;
    logic [1023:0] vrf_din_o;

    int errors = 0;
    int checks = 0;

    // slave configuration
    int          ar_wait = 0;
    bit          rv_rand = 1'b0;
    logic [35:0] err_addr = '1;

    // logs
    logic [35:0]   ar_addr_log [16];
    logic [7:0]    ar_len_log  [16];
    int            ar_n = 0;
    logic [9:0]    wr_addr_log [64];
    logic [1023:0] wr_data_log [64];
    int            wr_n = 0;
    int            done_n = 0;
    int            stab_err = 0;

    ma_vrf_load_mover #(
        .DDR4_ADDRWIDTH (36),
        .AXI_DATAWIDTH  (512),
        .VRF_ADDRWIDTH  (10),
        .VRF_DATAWIDTH  (1024),
        .MAX_BURST_BEATS(16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .src_axi_addr_i (src_axi_addr_i),
        .dst_bram_addr_i(dst_bram_addr_i),
        .byte_to_trans_i(byte_to_trans_i),
        .done_o         (done_o),
        .err_o          (err_o),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .vrf_en_o       (vrf_en_o),
        .vrf_we_o       (vrf_we_o),
        .vrf_addr_o     (vrf_addr_o),
        .vrf_din_o      (vrf_din_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] bdata(input logic [35:0] a);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) begin
            d[k*32 +: 32] = a[31:0] + 32'(k) * 32'h0101_0101 + 32'h5A00_0000;
        end
        return d;
    endfunction

    function automatic logic [1023:0] exp_row(input logic [35:0] a);
        return {bdata(a + 36'd64), bdata(a)};
    endfunction

    // AXI read slave: one idle cycle after the AR handshake, then the beats.
    initial begin : slave
        logic [35:0] a;
        logic [7:0]  l;
        logic [35:0] ba;
        int          g;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && m_axi_arvalid) begin
                a = m_axi_araddr;
                l = m_axi_arlen;
                if (ar_n < 16) begin
                    ar_addr_log[ar_n] = a;
                    ar_len_log[ar_n]  = l;
                end
                ar_n++;
                for (int d = 0; d < ar_wait && rst_n; d++) begin
                    @(posedge clk); #1;
                    if (rst_n && (m_axi_arvalid !== 1'b1 || m_axi_araddr !== a || m_axi_arlen !== l))
                        stab_err++;
                end
                if (rst_n) begin
                    m_axi_arready = 1'b1;
                    @(posedge clk); #1;
                    m_axi_arready = 1'b0;
                end
                for (int b = 0; b <= int'(l) && rst_n; b++) begin
                    @(posedge clk); #1;
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    if (rv_rand) begin
                        g = $urandom_range(0, 2);
                        repeat (g) begin @(posedge clk); #1; end
                    end
                    if (!rst_n) break;
                    ba           = a + 36'(b * 64);
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = bdata(ba);
                    m_axi_rresp  = (ba == err_addr) ? 2'b10 : 2'b00;
                    m_axi_rlast  = (b == int'(l));
                end
                @(posedge clk); #1;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                m_axi_rresp   = 2'b00;
                m_axi_arready = 1'b0;
            end
        end
    end

    // BRAM write / done monitor
    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (vrf_en_o && vrf_we_o) begin
                if (wr_n < 64) begin
                    wr_addr_log[wr_n] = vrf_addr_o;
                    wr_data_log[wr_n] = vrf_din_o;
                end
                wr_n++;
            end
            if (done_o) done_n++;
        end
    end

    task automatic run_cmd(input logic [35:0] src, input logic [9:0] dst,
                           input logic [14:0] bytes, output int lat);
        bit got;
        @(posedge clk); #1;
        ar_n = 0; wr_n = 0; done_n = 0; stab_err = 0;
        src_axi_addr_i  = src;
        dst_bram_addr_i = dst;
        byte_to_trans_i = bytes;
        start_i         = 1'b1;
        got = 1'b0;
        lat = -1;
        for (int c = 1; c <= 3000 && !got; c++) begin
            @(posedge clk); #1;
            if (c == 1) start_i = 1'b0;
            if (done_o) begin
                got = 1'b1;
                lat = c;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout src=%h bytes=%0d got=none exp=done_o", src, bytes);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0;
        src_axi_addr_i = '0; dst_bram_addr_i = '0; byte_to_trans_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({done_o, err_o, m_axi_arvalid, m_axi_rready, vrf_en_o, vrf_we_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {done_o, err_o, m_axi_arvalid, m_axi_rready, vrf_en_o, vrf_we_o});
        end
        checks++;
        if (m_axi_araddr !== 36'h0 || m_axi_arlen !== 8'h0 || vrf_addr_o !== 10'h0 || vrf_din_o !== '0) begin
            errors++;
            $display("FAIL reset_data got araddr=%h arlen=%h vaddr=%h exp=0", m_axi_araddr, m_axi_arlen, vrf_addr_o);
        end
        checks++;
        if (m_axi_arsize !== 3'd6 || m_axi_arburst !== 2'b01) begin
            errors++;
            $display("FAIL reset_const got size=%0d burst=%b exp size=6 burst=01", m_axi_arsize, m_axi_arburst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int lat;
        run_cmd(36'h1000, 10'd5, 15'd128, lat);
        checks++;
        if (lat != 6) begin errors++; $display("FAIL basic_latency got=%0d exp=6", lat); end
        checks++;
        if (ar_n != 1 || ar_addr_log[0] !== 36'h1000 || ar_len_log[0] !== 8'd1) begin
            errors++;
            $display("FAIL basic_ar got n=%0d addr=%h len=%0d exp n=1 addr=1000 len=1", ar_n, ar_addr_log[0], ar_len_log[0]);
        end
        checks++;
        if (wr_n != 1 || wr_addr_log[0] !== 10'd5) begin
            errors++;
            $display("FAIL basic_wr_addr got n=%0d addr=%0d exp n=1 addr=5", wr_n, wr_addr_log[0]);
        end
        checks++;
        if (wr_data_log[0] !== exp_row(36'h1000)) begin
            errors++;
            $display("FAIL basic_wr_data got[63:0]=%h exp[63:0]=%h", wr_data_log[0][63:0], exp_row(36'h1000) & 1024'hFFFF_FFFF_FFFF_FFFF);
        end
        checks++;
        if (done_n != 1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_err got done_n=%0d err=%b exp done_n=1 err=0", done_n, err_o);
        end
    endtask

    task automatic test_multi_burst();
        int lat;
        logic [1023:0] e;
        run_cmd(36'h0, 10'd20, 15'd2048, lat);
        checks++;
        if (ar_n != 2 || ar_addr_log[0] !== 36'h0 || ar_addr_log[1] !== 36'h400 ||
            ar_len_log[0] !== 8'd15 || ar_len_log[1] !== 8'd15) begin
            errors++;
            $display("FAIL multi_ar got n=%0d a0=%h a1=%h l0=%0d l1=%0d exp n=2 a0=0 a1=400 l=15",
                     ar_n, ar_addr_log[0], ar_addr_log[1], ar_len_log[0], ar_len_log[1]);
        end
        checks++;
        if (wr_n != 16 || done_n != 1) begin
            errors++;
            $display("FAIL multi_counts got wr=%0d done=%0d exp wr=16 done=1", wr_n, done_n);
        end
        for (int r = 0; r < 16 && r < wr_n; r++) begin
            e = exp_row(36'(r * 128));
            checks++;
            if (wr_addr_log[r] !== 10'(20 + r)) begin
                errors++;
                $display("FAIL multi_addr row %0d got=%0d exp=%0d", r, wr_addr_log[r], 20 + r);
            end
            checks++;
            if (wr_data_log[r] !== e) begin
                errors++;
                $display("FAIL multi_data row %0d got[63:0]=%h exp[63:0]=%h", r, wr_data_log[r][63:0], e[63:0]);
            end
        end
    endtask

    task automatic test_4k_split();
        int lat;
        run_cmd(36'hFC0, 10'd40, 15'd256, lat);
        checks++;
        if (ar_n != 2 || ar_addr_log[0] !== 36'hFC0 || ar_len_log[0] !== 8'd0 ||
            ar_addr_log[1] !== 36'h1000 || ar_len_log[1] !== 8'd2) begin
            errors++;
            $display("FAIL split_ar got n=%0d a0=%h l0=%0d a1=%h l1=%0d exp n=2 fc0/0 1000/2",
                     ar_n, ar_addr_log[0], ar_len_log[0], ar_addr_log[1], ar_len_log[1]);
        end
        checks++;
        if (wr_n != 2 || wr_addr_log[0] !== 10'd40 || wr_addr_log[1] !== 10'd41 ||
            wr_data_log[0] !== exp_row(36'hFC0) || wr_data_log[1] !== exp_row(36'h1040)) begin
            errors++;
            $display("FAIL split_rows got n=%0d a0=%0d a1=%0d d0[63:0]=%h exp n=2 a0=40 a1=41",
                     wr_n, wr_addr_log[0], wr_addr_log[1], wr_data_log[0][63:0]);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        ar_wait = 10; rv_rand = 1'b1;
        run_cmd(36'h1000, 10'd7, 15'd256, lat);
        ar_wait = 0; rv_rand = 1'b0;
        checks++;
        if (stab_err != 0 || ar_n != 1 || ar_addr_log[0] !== 36'h1000 || ar_len_log[0] !== 8'd3) begin
            errors++;
            $display("FAIL bp_ar got stab_err=%0d n=%0d addr=%h len=%0d exp 0/1/1000/3",
                     stab_err, ar_n, ar_addr_log[0], ar_len_log[0]);
        end
        checks++;
        if (wr_n != 2 || wr_addr_log[0] !== 10'd7 || wr_addr_log[1] !== 10'd8 ||
            wr_data_log[0] !== exp_row(36'h1000) || wr_data_log[1] !== exp_row(36'h1080) || done_n != 1) begin
            errors++;
            $display("FAIL bp_rows got n=%0d a0=%0d a1=%0d done=%0d exp n=2 a0=7 a1=8 done=1",
                     wr_n, wr_addr_log[0], wr_addr_log[1], done_n);
        end
    endtask

    task automatic test_error();
        int lat;
        err_addr = 36'h2040;
        run_cmd(36'h2000, 10'd50, 15'd128, lat);
        err_addr = '1;
        checks++;
        if (err_o !== 1'b1 || done_n != 1) begin
            errors++;
            $display("FAIL err_set got err=%b done=%0d exp err=1 done=1", err_o, done_n);
        end
        checks++;
        if (wr_n != 1 || wr_addr_log[0] !== 10'd50 || wr_data_log[0] !== exp_row(36'h2000)) begin
            errors++;
            $display("FAIL err_data got n=%0d addr=%0d exp n=1 addr=50", wr_n, wr_addr_log[0]);
        end
        run_cmd(36'h3000, 10'd51, 15'd128, lat);
        checks++;
        if (err_o !== 1'b0 || done_n != 1) begin
            errors++;
            $display("FAIL err_clear got err=%b done=%0d exp err=0 done=1", err_o, done_n);
        end
    endtask

    task automatic test_small();
        int lat;
        run_cmd(36'h4000, 10'd60, 15'd100, lat);
        checks++;
        if (ar_n != 0 || wr_n != 0 || lat < 1 || lat > 2 || done_n != 1) begin
            errors++;
            $display("FAIL small got ar=%0d wr=%0d lat=%0d done=%0d exp ar=0 wr=0 lat<=2 done=1",
                     ar_n, wr_n, lat, done_n);
        end
    endtask

    task automatic test_wrap();
        int lat;
        run_cmd(36'h5000, 10'd1023, 15'd256, lat);
        checks++;
        if (wr_n != 2 || wr_addr_log[0] !== 10'd1023 || wr_addr_log[1] !== 10'd0) begin
            errors++;
            $display("FAIL wrap_addr got n=%0d a0=%0d a1=%0d exp n=2 a0=1023 a1=0", wr_n, wr_addr_log[0], wr_addr_log[1]);
        end
        checks++;
        if (wr_data_log[1] !== exp_row(36'h5080)) begin
            errors++;
            $display("FAIL wrap_data got[63:0]=%h", wr_data_log[1][63:0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit hit;
        @(posedge clk); #1;
        wr_n = 0;
        src_axi_addr_i = 36'h6000; dst_bram_addr_i = 10'd3; byte_to_trans_i = 15'd512;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk); #1;
            if (wr_n >= 1) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rmid_progress got wr=%0d exp>=1", wr_n); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({done_o, err_o, m_axi_arvalid, m_axi_rready, vrf_en_o, vrf_we_o} !== 6'b0 ||
            vrf_din_o !== '0 || m_axi_araddr !== 36'h0) begin
            errors++;
            $display("FAIL rmid_outputs got=%b araddr=%h exp=000000 araddr=0",
                     {done_o, err_o, m_axi_arvalid, m_axi_rready, vrf_en_o, vrf_we_o}, m_axi_araddr);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_cmd(36'h7000, 10'd9, 15'd128, lat);
        checks++;
        if (wr_n != 1 || wr_addr_log[0] !== 10'd9 || wr_data_log[0] !== exp_row(36'h7000) || done_n != 1) begin
            errors++;
            $display("FAIL rmid_recover got n=%0d addr=%0d done=%0d exp n=1 addr=9 done=1", wr_n, wr_addr_log[0], done_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_burst();
        test_4k_split();
        test_backpressure();
        test_error();
        test_small();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
